// File: rtl/sd_pattern_src_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pattern_src_if
//  Description : FIFO-style read port between a pattern source and the SD
//                writer. The source presents full/empty flags and registered
//                read data. The writer pulses rd_req_en to pop one word.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sd_pattern_src_if #(
    parameter int DATA_W = 16
) ();
    logic              rd_req_en;
    logic [DATA_W-1:0] rd_data;
    logic              full_flag;
    logic              empty_flag;

    // Data source side.
    modport master (
        input  rd_req_en,
        output rd_data,
        output full_flag,
        output empty_flag
    );

    // Reader side, i.e. the SD writer.
    modport slave (
        output rd_req_en,
        input  rd_data,
        input  full_flag,
        input  empty_flag
    );
endinterface
`default_nettype wire

// File: rtl/sd_pattern_src.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pattern_src
//  Description : Test-data source for the SD write path. A debounced save key
//                or a software trigger starts one image. The block pulses
//                save_req and then serves SECTORS x SECTOR_WORDS pattern words
//                through a non-showahead FIFO read port. It finishes with an
//                image_done pulse.
//                Optional feature macro: SD_PAT_CHKSUM_EN. When it is defined,
//                chk_sum carries a 16-bit running sum of the emitted words.
//                When it is undefined, chk_sum is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_pattern_src #(
    parameter int                DATA_W       = 16,
    parameter int                SECTOR_WORDS = 256,
    parameter int                SECTORS      = 8,
    parameter int                HOLD_TIME    = 500_000,
    parameter logic [DATA_W-1:0] LFSR_TAPS    = 16'hB400,
    parameter logic [DATA_W-1:0] LFSR_SEED    = 16'hACE1
) (
    input  wire logic              sys_clk,
    input  wire logic              sys_rst,
    input  wire logic              key_save_sd,
    input  wire logic              sw_trig,
    input  wire logic [1:0]        mode,
    input  wire logic [DATA_W-1:0] const_pat,
    output logic                   save_req,
    output logic                   image_done,
    output logic                   busy,
    output logic [15:0]            chk_sum,
    sd_pattern_src_if.master       rd_port
);

    localparam int WC_W = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;
    localparam int HC_W = (HOLD_TIME > 1) ? $clog2(HOLD_TIME + 1) : 1;

    localparam logic [WC_W-1:0]   WORD_LAST = WC_W'(SECTOR_WORDS - 1);
    localparam logic [15:0]       SEC_LAST  = 16'(SECTORS - 1);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_TIME - 1);
    // Mode 3 places the sector index in the top byte. The remaining low
    // DATA_W-8 bits carry the word index. The mask is zero when DATA_W is 8.
    localparam logic [DATA_W-1:0] K_MASK    = DATA_W'((64'd1 << (DATA_W - 8)) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Key synchroniser and debouncer
    // ------------------------------------------------------------------
    logic            key_s1_q, key_s2_q;
    logic            db_level_q, db_level_d;
    logic [HC_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;

    // Count consecutive samples that disagree with the debounced level.
    // Any agreeing sample restarts the count.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        press_d    = 1'b0;
        if (key_s2_q != db_level_q) begin
            if (db_cnt_q == HOLD_LAST) begin
                db_level_d = key_s2_q;
                press_d    = ~key_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + HC_W'(1);
            end
        end
    end

    // The synchroniser and debouncer registers reset to the released-key level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_s1_q   <= 1'b1;
            key_s2_q   <= 1'b1;
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            key_s1_q   <= key_save_sd;
            key_s2_q   <= key_s1_q;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and pattern generator
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [1:0]        mode_lat_q, mode_lat_d;
    logic [DATA_W-1:0] const_lat_q, const_lat_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [15:0]       sec_cnt_q, sec_cnt_d;
    logic [DATA_W-1:0] glob_cnt_q, glob_cnt_d;
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              full_q, full_d;
    logic              save_req_q, save_req_d;
    logic              image_done_q, image_done_d;
    logic              busy_q, busy_d;

    logic              w_trig;
    logic              w_start;
    logic              w_accept;
    logic              w_last;
    logic [DATA_W-1:0] w_pat;
    logic [DATA_W-1:0] w_lfsr_step;

    assign w_trig   = press_q | sw_trig;
    assign w_start  = (state_q == ST_IDLE) && w_trig;
    assign w_accept = (state_q == ST_STREAM) && rd_port.rd_req_en;
    assign w_last   = (word_cnt_q == WORD_LAST) && (sec_cnt_q == SEC_LAST);

    // Galois step: shift right and fold in the taps when a 1 falls out.
    assign w_lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    // Select the word for the current position from the mode latched at start.
    always_comb begin
        w_pat = const_lat_q;
        case (mode_lat_q)
            2'd0:    w_pat = const_lat_q;
            2'd1:    w_pat = glob_cnt_q;
            2'd2:    w_pat = lfsr_q;
            default: w_pat = (DATA_W'(sec_cnt_q[7:0]) << (DATA_W - 8))
                           | (DATA_W'(word_cnt_q) & K_MASK);
        endcase
    end

    // Next-state logic. save_req and image_done are one-cycle pulses.
    // The read port only advances in STREAM.
    always_comb begin
        state_d      = state_q;
        mode_lat_d   = mode_lat_q;
        const_lat_d  = const_lat_q;
        word_cnt_d   = word_cnt_q;
        sec_cnt_d    = sec_cnt_q;
        glob_cnt_d   = glob_cnt_q;
        lfsr_d       = lfsr_q;
        rd_data_d    = rd_data_q;
        full_d       = full_q;
        save_req_d   = 1'b0;
        image_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_trig) begin
                    mode_lat_d  = mode;
                    const_lat_d = const_pat;
                    word_cnt_d  = '0;
                    sec_cnt_d   = '0;
                    glob_cnt_d  = '0;
                    lfsr_d      = LFSR_SEED;
                    state_d     = ST_ARM;
                end
            end
            ST_ARM: begin
                save_req_d = 1'b1;
                full_d     = 1'b1;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                if (rd_port.rd_req_en) begin
                    rd_data_d  = w_pat;
                    glob_cnt_d = glob_cnt_q + DATA_W'(1);
                    lfsr_d     = w_lfsr_step;
                    if (word_cnt_q == WORD_LAST) begin
                        word_cnt_d = '0;
                        sec_cnt_d  = sec_cnt_q + 16'd1;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                    if (w_last) begin
                        full_d       = 1'b0;
                        image_done_d = 1'b1;
                        state_d      = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // All sequencer state and the visible outputs are registered here.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            mode_lat_q   <= 2'd0;
            const_lat_q  <= '0;
            word_cnt_q   <= '0;
            sec_cnt_q    <= '0;
            glob_cnt_q   <= '0;
            lfsr_q       <= LFSR_SEED;
            rd_data_q    <= '0;
            full_q       <= 1'b0;
            save_req_q   <= 1'b0;
            image_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_lat_q   <= mode_lat_d;
            const_lat_q  <= const_lat_d;
            word_cnt_q   <= word_cnt_d;
            sec_cnt_q    <= sec_cnt_d;
            glob_cnt_q   <= glob_cnt_d;
            lfsr_q       <= lfsr_d;
            rd_data_q    <= rd_data_d;
            full_q       <= full_d;
            save_req_q   <= save_req_d;
            image_done_q <= image_done_d;
            busy_q       <= busy_d;
        end
    end

    assign save_req           = save_req_q;
    assign image_done         = image_done_q;
    assign busy               = busy_q;
    assign rd_port.rd_data    = rd_data_q;
    assign rd_port.full_flag  = full_q;
    assign rd_port.empty_flag = ~full_q;

    // ------------------------------------------------------------------
    // Optional image checksum
    // ------------------------------------------------------------------
`ifdef SD_PAT_CHKSUM_EN
    logic [15:0] sum_q, sum_d;

    // The sum adds each word as it is emitted. A start clears it. It then
    // holds from image_done until the next start.
    always_comb begin
        sum_d = sum_q;
        if (w_start) begin
            sum_d = 16'd0;
        end else if (w_accept) begin
            sum_d = sum_q + 16'(w_pat);
        end
    end

    // Checksum register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sum_q <= 16'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign chk_sum = sum_q;
`else
    logic w_unused_sum;
    assign w_unused_sum = w_start ^ w_accept;
    assign chk_sum      = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_pattern_src.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_pattern_src
//  Description : Self-checking bench for sd_pattern_src. It uses random
//                strobes and modes. A word-index model derives the expected
//                pattern words and checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_pattern_src;

    localparam int DW = 16;
    localparam int SW = 256;
    localparam int NS = 3;
    localparam int HT = 16;
    localparam int NWORDS = SW * NS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key = 1'b1;
    logic          trig = 1'b0;
    logic          rd_en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] cpat = '0;
    wire           save_req;
    wire           image_done;
    wire           busy;
    wire [15:0]    chk_sum;

    sd_pattern_src_if #(.DATA_W(DW)) rd_if ();
    assign rd_if.rd_req_en = rd_en;

    sd_pattern_src #(
        .DATA_W       (DW),
        .SECTOR_WORDS (SW),
        .SECTORS      (NS),
        .HOLD_TIME    (HT),
        .LFSR_TAPS    (16'hB400),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .key_save_sd (key),
        .sw_trig     (trig),
        .mode        (mode),
        .const_pat   (cpat),
        .save_req    (save_req),
        .image_done  (image_done),
        .busy        (busy),
        .chk_sum     (chk_sum),
        .rd_port     (rd_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state of the image in progress.
    logic [1:0]  m_mode;
    logic [15:0] m_const;
    logic [15:0] m_lfsr;
    logic [15:0] m_sum;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Expected word at global position idx of the current image.
    function automatic logic [15:0] model_word(input int idx);
        logic [15:0] s;
        logic [15:0] k;
        s = 16'(idx / SW);
        k = 16'(idx % SW);
        case (m_mode)
            2'd0:    return m_const;
            2'd1:    return 16'(idx);
            2'd2:    return m_lfsr;
            default: return {s[7:0], k[7:0]};
        endcase
    endfunction

    function automatic logic [15:0] exp_chk();
`ifdef SD_PAT_CHKSUM_EN
        return m_sum;
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_start(input logic [1:0] md, input logic [15:0] cp);
        m_mode  = md;
        m_const = cp;
        m_lfsr  = 16'hACE1;
        m_sum   = 16'd0;
    endtask

    task automatic sw_start(input logic [1:0] md, input logic [15:0] cp);
        mode = md;
        cpat = cp;
        trig = 1'b1;
        model_start(md, cp);
        step();
        trig = 1'b0;
        mode = 2'($urandom);
        cpat = 16'($urandom);
        check_val("arm_no_req", save_req, 0);
        check_val("arm_busy", busy, 1);
        step();
        check_val("save_req", save_req, 1);
        check_val("stream_full", rd_if.full_flag, 1);
        check_val("stream_empty", rd_if.empty_flag, 0);
    endtask

    // Serve one image with random strobes starting in the save_req cycle.
    // When abort_at > 0, reset is asserted after that many reads.
    task automatic stream_image(input int abort_at);
        int          idx;
        int          cyc;
        int          idle10;
        bit          s;
        bit          done;
        logic [15:0] last;
        logic [15:0] e;
        idx    = 0;
        cyc    = 0;
        idle10 = 10;
        done   = 1'b0;
        last   = rd_if.rd_data;
        while (!done && cyc < 20000) begin
            s = ($urandom_range(0, 3) != 0);
            if (idx == 40 && idle10 > 0) begin
                s = 1'b0;
                idle10--;
            end
            trig  = ($urandom_range(0, 63) == 0);
            rd_en = s;
            step();
            cyc++;
            check_val("no_restart", save_req, 0);
            if (s) begin
                e = model_word(idx);
                check_val($sformatf("word%0d", idx), rd_if.rd_data, e);
                last  = e;
                m_sum = m_sum + e;
                m_lfsr = lfsr_next(m_lfsr);
                idx++;
                if (idx == NWORDS) begin
                    check_val("final_full", rd_if.full_flag, 0);
                    check_val("final_empty", rd_if.empty_flag, 1);
                    check_val("final_done", image_done, 1);
                    done = 1'b1;
                end else begin
                    check_val("mid_full", rd_if.full_flag, 1);
                    check_val("mid_done", image_done, 0);
                end
                if (abort_at > 0 && idx == abort_at) begin
                    rd_en = 1'b0;
                    trig  = 1'b0;
                    rst   = 1'b1;
                    step();
                    check_val("rst_full", rd_if.full_flag, 0);
                    check_val("rst_empty", rd_if.empty_flag, 1);
                    check_val("rst_busy", busy, 0);
                    check_val("rst_data", rd_if.rd_data, 0);
                    check_val("rst_done", image_done, 0);
                    check_val("rst_chk", chk_sum, 0);
                    rst = 1'b0;
                    step();
                    check_val("rst_no_done", image_done, 0);
                    return;
                end
            end else begin
                check_val("hold_data", rd_if.rd_data, last);
                check_val("hold_full", rd_if.full_flag, 1);
                check_val("hold_done", image_done, 0);
            end
        end
        rd_en = 1'b0;
        trig  = 1'b0;
        check_val("stream_completed", done, 1);
        // The DONE cycle is current: a trigger and strobes here must be ignored.
        trig  = 1'b1;
        rd_en = 1'b1;
        step();
        trig = 1'b0;
        check_val("done_pulse_end", image_done, 0);
        check_val("idle_busy", busy, 0);
        check_val("post_full", rd_if.full_flag, 0);
        check_val("post_data", rd_if.rd_data, last);
        check_val("chk_sum", chk_sum, exp_chk());
        step();
        check_val("post_busy", busy, 0);
        step();
        check_val("done_trig_dropped", save_req, 0);
        check_val("chk_stable", chk_sum, exp_chk());
        rd_en = 1'b0;
    endtask

    initial begin
        int n_req;
        int lat;
        bit seen;

        repeat (3) step();
        rst = 1'b0;
        check_val("rst_save_req", save_req, 0);
        check_val("rst_full", rd_if.full_flag, 0);
        check_val("rst_empty", rd_if.empty_flag, 1);
        check_val("rst_rd_data", rd_if.rd_data, 0);
        check_val("rst_image_done", image_done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_chk_sum", chk_sum, 0);

        // A strobe in IDLE must not change anything.
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_val("idle_strobe_data", rd_if.rd_data, 0);
        check_val("idle_strobe_busy", busy, 0);

        sw_start(2'd0, 16'h00A5);
        stream_image(0);

        sw_start(2'd1, 16'h0000);
        stream_image(100);
        sw_start(2'd1, 16'h0000);
        stream_image(0);

        sw_start(2'd2, 16'h1234);
        stream_image(0);

        sw_start(2'd3, 16'h5678);
        stream_image(0);

        // Bouncing key followed by a stable press.
        mode = 2'd3;
        cpat = 16'h0000;
        model_start(2'd3, 16'h0000);
        n_req = 0;
        for (int b = 0; b < 3; b++) begin
            key = 1'b0;
            for (int c = 0; c < 8; c++) begin
                step();
                if (save_req) n_req++;
            end
            key = 1'b1;
            for (int c = 0; c < 2; c++) begin
                step();
                if (save_req) n_req++;
            end
        end
        key  = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            step();
            lat++;
            if (save_req) begin
                seen = 1'b1;
                n_req++;
            end
        end
        check_val("key_press_seen", seen, 1);
        check_val("key_latency", lat, HT + 4);
        check_val("key_stream_full", rd_if.full_flag, 1);
        stream_image(0);
        for (int c = 0; c < 100; c++) begin
            step();
            if (save_req) n_req++;
        end
        check_val("key_single_start", n_req, 1);
        key = 1'b1;
        repeat (HT + 8) step();
        check_val("key_release_idle", busy, 0);

        // Random modes and constants.
        for (int r = 0; r < 2; r++) begin
            sw_start(2'($urandom_range(0, 3)), 16'($urandom));
            stream_image(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
